// File: rtl/tm_pkg.sv
// tm_pkg: definitions shared by the Tsetlin machine clause sequencer and the
// clause-voting logic.
//   state_e            : clause sequencer states
//   FB_NONE/TYPE1/TYPE2: encodings of the feedback_sel request
//   LFSR_WIDTH/TAPS    : 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1
//   DEFAULT_LFSR_SEED  : default (nonzero) LFSR reset value
//   lfsr_next()        : one LFSR step
package tm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EVAL     = 3'd1,
        ST_RESULT   = 3'd2,
        ST_FEEDBACK = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [1:0] FB_NONE  = 2'b00;
    localparam logic [1:0] FB_TYPE1 = 2'b01;
    localparam logic [1:0] FB_TYPE2 = 2'b10;

    localparam int LFSR_WIDTH = 16;

    // The register shifts toward bit 0, so taps 16,14,13,11 of the
    // polynomial land on register bits 0,2,3,5.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS         = 16'h002D;
    localparam logic [LFSR_WIDTH-1:0] DEFAULT_LFSR_SEED = 16'hACE1;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/tm_lfsr16.sv
// tm_lfsr16: free-running 16-bit Fibonacci LFSR, advancing every clock.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-low reset, loads SEED
//   out  out  [15:0] current LFSR state
// SEED must be nonzero, otherwise the register locks up at zero.
module tm_lfsr16
    import tm_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [LFSR_WIDTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out <= SEED;
        end else begin
            out <= lfsr_next(out);
        end
    end

endmodule

// File: rtl/clause_ctrl.sv
// clause_ctrl: sequences one clause's bank of 2*N_LIT Tsetlin automata through
// an inference phase and, when training, a feedback phase.
// Ports:
//   clk, rst (sync, active-low)
//   start, train, feedback_sel[1:0], literals[N_LIT-1:0]  request (latched at start)
//   ta_enable[N_TA-1:0], ta_training_sel, ta_literal[N_TA-1:0],
//   ta_type_feedback, ta_clause_result, ta_rand           to the automata
//   ta_done[N_TA-1:0], ta_result[N_TA-1:0]                from the automata
//   busy, valid, clause_out, timeout_err                  status / result
// Optional feature: define CLAUSE_CTRL_TIMEOUT_EN to bound the EVAL and
// FEEDBACK waits to TIMEOUT cycles; otherwise they wait indefinitely and
// timeout_err is tied low.
module clause_ctrl
    import tm_pkg::*;
#(
    parameter int                    N_LIT     = 8,
    parameter int                    TIMEOUT   = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = DEFAULT_LFSR_SEED,
    parameter int                    N_TA      = 2 * N_LIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             train,
    input  logic [1:0]       feedback_sel,
    input  logic [N_LIT-1:0] literals,
    output logic [N_TA-1:0]  ta_enable,
    output logic             ta_training_sel,
    output logic [N_TA-1:0]  ta_literal,
    output logic             ta_type_feedback,
    output logic             ta_clause_result,
    output logic             ta_rand,
    input  logic [N_TA-1:0]  ta_done,
    input  logic [N_TA-1:0]  ta_result,
    output logic             busy,
    output logic             valid,
    output logic             clause_out,
    output logic             timeout_err
);

    state_e                state_reg, state_next;
    logic [N_LIT-1:0]      lit_q;
    logic                  train_q;
    logic [1:0]            fb_q;
    logic [N_TA-1:0]       inc_q;
    logic                  clause_q;
    logic [N_TA-1:0]       lit_full;
    logic [N_TA-1:0]       term;
    logic                  clause_val;
    logic                  all_done;
    logic                  waiting;
    logic                  fb_go;
    logic                  wait_hit;
    logic                  timeout_fire;
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic                  unused_lfsr;

    assign lit_full = {~lit_q, lit_q};
    assign all_done = &ta_done;
    assign waiting  = (state_reg == ST_EVAL) || (state_reg == ST_FEEDBACK);
    assign fb_go    = train_q && ((fb_q == FB_TYPE1) || (fb_q == FB_TYPE2));

    // A literal only constrains the clause when its automaton votes include.
    generate
        for (genvar gi = 0; gi < N_TA; gi++) begin : g_term
            assign term[gi] = ~inc_q[gi] | lit_full[gi];
        end
    endgenerate

    // An empty clause fires during training so it can collect feedback,
    // but never contributes a vote at inference time.
    assign clause_val = (inc_q == '0) ? train_q : &term;

`ifdef CLAUSE_CTRL_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_reg;
    logic       timeout_err_reg;

    assign wait_hit = (wait_cnt_reg == WAIT_LIMIT);

    // Restarts on every state change, so entering EVAL or FEEDBACK begins at 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
            end else if (waiting) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
            if (timeout_fire) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign wait_hit       = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // A completing handshake wins over a timeout in the same cycle.
    assign timeout_fire = waiting && !all_done && wait_hit;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:     if (start) state_next = ST_EVAL;
            ST_EVAL: begin
                if (all_done)          state_next = ST_RESULT;
                else if (timeout_fire) state_next = ST_DONE;
            end
            ST_RESULT:   state_next = fb_go ? ST_FEEDBACK : ST_DONE;
            ST_FEEDBACK: if (all_done || timeout_fire) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            lit_q     <= '0;
            train_q   <= 1'b0;
            fb_q      <= FB_NONE;
            inc_q     <= '0;
            clause_q  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                lit_q   <= literals;
                train_q <= train;
                fb_q    <= feedback_sel;
            end
            if (state_reg == ST_EVAL && all_done) begin
                inc_q <= ta_result;
            end
            if (state_reg == ST_RESULT) begin
                clause_q <= clause_val;
            end else if (timeout_fire) begin
                clause_q <= 1'b0;
            end
        end
    end

    tm_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[LFSR_WIDTH-1:1];

    assign busy             = (state_reg != ST_IDLE);
    assign valid            = (state_reg == ST_DONE);
    assign ta_enable        = {N_TA{waiting}};
    assign ta_training_sel  = (state_reg == ST_FEEDBACK);
    // Literals are only presented while a request is in flight.
    assign ta_literal       = busy ? lit_full : '0;
    assign ta_type_feedback = fb_q[1];
    assign ta_clause_result = clause_q;
    assign clause_out       = clause_q;
    assign ta_rand          = lfsr_q[0];

endmodule

// File: tb/tb_clause_ctrl.sv
// Self-checking bench for clause_ctrl (N_LIT=8): directed cases plus
// randomized transactions against a behavioural clause and LFSR-stream model.
module tb_clause_ctrl;

    localparam int          N_LIT = 8;
    localparam int          N_TA  = 16;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            train;
    logic [1:0]      feedback_sel;
    logic [N_LIT-1:0] literals;
    logic [N_TA-1:0] ta_enable;
    logic            ta_training_sel;
    logic [N_TA-1:0] ta_literal;
    logic            ta_type_feedback;
    logic            ta_clause_result;
    logic            ta_rand;
    logic [N_TA-1:0] ta_done;
    logic [N_TA-1:0] ta_result;
    logic            busy;
    logic            valid;
    logic            clause_out;
    logic            timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    clause_ctrl #(
        .N_LIT     (8),
        .TIMEOUT   (16),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .train            (train),
        .feedback_sel     (feedback_sel),
        .literals         (literals),
        .ta_enable        (ta_enable),
        .ta_training_sel  (ta_training_sel),
        .ta_literal       (ta_literal),
        .ta_type_feedback (ta_type_feedback),
        .ta_clause_result (ta_clause_result),
        .ta_rand          (ta_rand),
        .ta_done          (ta_done),
        .ta_result        (ta_result),
        .busy             (busy),
        .valid            (valid),
        .clause_out       (clause_out),
        .timeout_err      (timeout_err)
    );

    // Output stream model: x[n+16] = x[n] ^ x[n+2] ^ x[n+3] ^ x[n+5],
    // seeded with x[0..15] = SEED[0..15]; ta_rand shows x[n] at cycle n.
    bit stream_q[$];
    bit stream_new;
    always @(posedge clk) begin
        if (!rst) begin
            stream_q.delete();
            for (int i = 0; i < 16; i++) stream_q.push_back(SEED[i]);
        end else begin
            stream_new = stream_q[0] ^ stream_q[2] ^ stream_q[3] ^ stream_q[5];
            void'(stream_q.pop_front());
            stream_q.push_back(stream_new);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("ta_rand", {15'd0, ta_rand}, {15'd0, stream_q[0]});
    endtask

    function automatic bit model_clause(input logic [7:0] lit, input logic [15:0] res, input bit tr);
        bit lv;
        if (res == 16'd0) return tr;
        for (int i = 0; i < 16; i++) begin
            lv = (i < 8) ? lit[i] : !lit[i-8];
            if (res[i] && !lv) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] partial_done();
        return ~(16'h0001 << $urandom_range(15));
    endfunction

    // One full request; d_eval / d_fb = cycles each phase waits on a partial done.
    task automatic txn(input logic [7:0] lit, input logic [15:0] res, input bit tr,
                       input logic [1:0] fb, input int d_eval, input int d_fb);
        bit exp_c;
        bit exp_fb;
        int vcnt;
        exp_c  = model_clause(lit, res, tr);
        exp_fb = tr && (fb == 2'b01 || fb == 2'b10);
        literals     = lit;
        train        = tr;
        feedback_sel = fb;
        ta_result    = res;
        ta_done      = (d_eval == 0) ? 16'hFFFF : partial_done();
        start        = 1'b1;
        step();
        start = 1'b0;
        vcnt  = valid;
        for (int j = 0; j <= d_eval; j++) begin
            if (j == d_eval) ta_done = 16'hFFFF;
            chk("eval_enable", ta_enable, 16'hFFFF);
            chk("eval_tsel", {15'd0, ta_training_sel}, 16'd0);
            chk("eval_literal", ta_literal, {~lit, lit});
            chk("eval_busy", {15'd0, busy}, 16'd1);
            step();
            vcnt += valid;
        end
        chk("result_enable", ta_enable, 16'h0000);
        chk("result_valid", {15'd0, valid}, 16'd0);
        if (exp_fb) ta_done = (d_fb == 0) ? 16'hFFFF : partial_done();
        step();
        vcnt += valid;
        chk("clause_result", {15'd0, ta_clause_result}, {15'd0, exp_c});
        chk("clause_out", {15'd0, clause_out}, {15'd0, exp_c});
        if (exp_fb) begin
            for (int j = 0; j <= d_fb; j++) begin
                if (j == d_fb) ta_done = 16'hFFFF;
                chk("fb_enable", ta_enable, 16'hFFFF);
                chk("fb_tsel", {15'd0, ta_training_sel}, 16'd1);
                chk("fb_type", {15'd0, ta_type_feedback}, {15'd0, fb[1]});
                chk("fb_clause_result", {15'd0, ta_clause_result}, {15'd0, exp_c});
                step();
                vcnt += valid;
            end
        end
        chk("done_valid", {15'd0, valid}, 16'd1);
        chk("done_clause", {15'd0, clause_out}, {15'd0, exp_c});
        step();
        vcnt += valid;
        chk("idle_busy", {15'd0, busy}, 16'd0);
        chk("valid_once", vcnt[15:0], 16'd1);
        chk("clause_hold", {15'd0, clause_out}, {15'd0, exp_c});
        $display("[TB] txn lit=%h res=%h train=%0d fb=%0d clause=%0d expected=%0d",
                 lit, res, tr, fb, clause_out, exp_c);
    endtask

    initial begin
        logic [7:0]  lit;
        logic [15:0] r;
        int          cyc;

        rst = 1'b0; start = 1'b0; train = 1'b0; feedback_sel = 2'b00;
        literals = '0; ta_done = '0; ta_result = '0;
        step();
        step();
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_enable", ta_enable, 16'd0);
        chk("rst_literal", ta_literal, 16'd0);
        chk("rst_tsel", {15'd0, ta_training_sel}, 16'd0);
        chk("rst_type", {15'd0, ta_type_feedback}, 16'd0);
        chk("rst_cres", {15'd0, ta_clause_result}, 16'd0);
        chk("rst_clause", {15'd0, clause_out}, 16'd0);
        chk("rst_terr", {15'd0, timeout_err}, 16'd0);
        chk("rst_rand", {15'd0, ta_rand}, {15'd0, SEED[0]});
        rst = 1'b1;
        step();

        // Latency: valid seen on the third cycle after the start edge.
        literals = 8'hA5; ta_result = 16'h0005; ta_done = 16'hFFFF; train = 1'b0;
        feedback_sel = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        chk("lat_eval", ta_enable, 16'hFFFF);
        step();
        chk("lat_result_valid", {15'd0, valid}, 16'd0);
        step();
        chk("lat_valid", {15'd0, valid}, 16'd1);
        chk("lat_clause", {15'd0, clause_out}, 16'd1);
        step();

        txn(8'hA5, 16'h0005, 1'b0, 2'b00, 0, 0);     // clause true
        txn(8'hA5, 16'h0002, 1'b0, 2'b00, 0, 0);     // lit1=0 -> false
        txn(8'hA5, 16'h0000, 1'b0, 2'b00, 0, 0);     // empty, inference
        txn(8'hA5, 16'h0000, 1'b1, 2'b00, 0, 0);     // empty, training
        txn(8'hA5, 16'h0005, 1'b1, 2'b10, 3, 3);     // Type II feedback
        txn(8'h3C, 16'h4204, 1'b1, 2'b01, 2, 1);     // Type I feedback
        txn(8'h3C, 16'h0004, 1'b1, 2'b11, 1, 0);     // 11 treated as none

        // Start during DONE is ignored, accepted on the following IDLE cycle.
        literals = 8'hA5; ta_result = 16'h0005; ta_done = 16'hFFFF; train = 1'b0;
        feedback_sel = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("sd_valid", {15'd0, valid}, 16'd1);
        start = 1'b1;
        step();
        chk("sd_ignored", {15'd0, busy}, 16'd0);
        step();
        start = 1'b0;
        chk("sd_accepted", {15'd0, busy}, 16'd1);
        step();
        step();
        chk("sd_valid2", {15'd0, valid}, 16'd1);
        step();

        // Reset during FEEDBACK.
        literals = 8'h5A; ta_result = 16'h0002; ta_done = 16'hFFFF; train = 1'b1;
        feedback_sel = 2'b01; start = 1'b1;
        step();
        start = 1'b0;
        step();
        ta_done = partial_done();
        step();
        chk("mr_in_fb", {15'd0, ta_training_sel}, 16'd1);
        rst = 1'b0;
        step();
        chk("mr_busy", {15'd0, busy}, 16'd0);
        chk("mr_enable", ta_enable, 16'd0);
        chk("mr_valid", {15'd0, valid}, 16'd0);
        chk("mr_rand_seed", {15'd0, ta_rand}, {15'd0, SEED[0]});
        rst = 1'b1;
        step();
        chk("mr_valid2", {15'd0, valid}, 16'd0);
        txn(8'hA5, 16'h0005, 1'b0, 2'b00, 0, 0);

        for (int t = 0; t < 24; t++) begin
            lit = 8'($urandom);
            r   = 16'($urandom & $urandom & $urandom);
            if (t % 2 == 1) r = r & {~lit, lit};
            txn(lit, r, 1'($urandom_range(1)), 2'($urandom_range(3)),
                int'($urandom_range(3)), int'($urandom_range(3)));
        end

`ifdef CLAUSE_CTRL_TIMEOUT_EN
        literals = 8'hA5; ta_result = 16'h0005; train = 1'b1; feedback_sel = 2'b01;
        ta_done = partial_done(); start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (!valid && cyc < 40) begin
            step();
            cyc++;
        end
        chk("to_cycles", cyc[15:0], 16'd17);
        chk("to_err", {15'd0, timeout_err}, 16'd1);
        chk("to_clause", {15'd0, clause_out}, 16'd0);
        ta_done = 16'hFFFF;
        step();
        chk("to_idle", {15'd0, busy}, 16'd0);
        txn(8'hA5, 16'h0005, 1'b0, 2'b00, 0, 0);
        chk("to_sticky", {15'd0, timeout_err}, 16'd1);
`else
        cyc = 0;
        txn(8'hA5, 16'h0005, 1'b0, 2'b00, 30, 0);    // long partial done
        chk("no_timeout", {15'd0, timeout_err}, 16'd0);
        chk("no_timeout_cyc", cyc[15:0], 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
